// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline sequencer states and opcode constants
// used by the decoder and the pipeline control unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    // JMP and JAL share the 4'hC major opcode; the decoder splits them by a sub-field.
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_JAL   = 4'hC;
    localparam logic [3:0] OP_JR    = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

endpackage

// File: rtl/load_scoreboard.sv
// Tracks destination registers of loads still in flight and flags an ID
// instruction that reads one of them before its data can be forwarded.
module load_scoreboard
    import cpu_pkg::*;
#(
    parameter int LOAD_LAT  = 1,
    parameter int REGADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift_en,
    input  logic                 push_v,
    input  logic [REGADDR_W-1:0] push_rd,
    input  logic                 id_valid,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    output logic                 load_stall
);

    logic [LOAD_LAT-1:0]  v;
    logic [REGADDR_W-1:0] rd [LOAD_LAT];
    logic                 hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            for (int unsigned i = 0; i < LOAD_LAT; i++) rd[i] <= '0;
        end else if (shift_en) begin
            for (int unsigned i = 1; i < LOAD_LAT; i++) begin
                v[i]  <= v[i-1];
                rd[i] <= rd[i-1];
            end
            v[0]  <= push_v;
            rd[0] <= push_rd;
        end
    end

    // R0 is hard-wired zero, so a load targeting it never creates a hazard.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            if (v[i] && (rd[i] != '0) &&
                ((id_use_rs && (rd[i] == id_rs)) || (id_use_rt && (rd[i] == id_rt))))
                hit = 1'b1;
        end
    end

    assign load_stall = id_valid & hit;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencer: owns PC/IF-ID/ID-EX enables and flushes, handles load-use
// stalls, data-memory wait holds, drain-then-halt with resume, and a stall counter.
module pipe_ctrl_unit
    import cpu_pkg::*;
#(
    parameter int REGADDR_W = 4,
    parameter int LOAD_LAT  = 1,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic [REGADDR_W-1:0] id_rd,
    input  logic                 id_is_load,
    input  logic                 id_jump,
    input  logic                 id_halt,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 resume,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 pipe_hold,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    pipe_state_t   state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          held, load_stall, push_v;

    assign held   = mem_req & ~mem_ready;
    assign push_v = id_valid & id_is_load & ~load_stall & ~id_ex_flush;

    load_scoreboard #(
        .LOAD_LAT  (LOAD_LAT),
        .REGADDR_W (REGADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (~held),
        .push_v     (push_v),
        .push_rd    (id_rd),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .load_stall (load_stall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // A memory hold overrides every other decision, so state and count only move on non-held cycles.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        halted      = 1'b0;
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        if (!reset) begin
            halted = (state == HALTED);
            if (held) begin
                pipe_hold = 1'b1;
            end else begin
                case (state)
                    HALTED: begin
                        if (resume) state_nxt = RUN;
                    end
                    DRAIN: begin
                        id_ex_flush = 1'b1;
                        if (drain_cnt <= DW'(1)) state_nxt = HALTED;
                        else                     drain_nxt = drain_cnt - DW'(1);
                    end
                    default: begin
                        if (load_stall) begin
                            id_ex_flush = 1'b1;
                        end else if (id_valid && id_halt) begin
                            id_ex_flush = 1'b1;
                            if_id_flush = 1'b1;
                            if (DRAIN_CYC == 0) begin
                                state_nxt = HALTED;
                            end else begin
                                state_nxt = DRAIN;
                                drain_nxt = DW'(DRAIN_CYC);
                            end
                        end else if (id_valid && id_jump) begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                            if_id_flush = 1'b1;
                        end else begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if ((state == RUN) && !pc_write && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: three instances (LOAD_LAT=1/DRAIN_CYC=3,
// LOAD_LAT=3/DRAIN_CYC=3, LOAD_LAT=1/DRAIN_CYC=0 with a 2-bit counter) share stimulus.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_is_load, id_jump, id_halt;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       mem_req, mem_ready, resume;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_pipe_hold, a_halted;
    logic [15:0] a_stall_cnt;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_pipe_hold, b_halted;
    logic [15:0] b_stall_cnt;
    logic        c_pc_write, c_if_id_write, c_if_id_flush, c_id_ex_flush, c_pipe_hold, c_halted;
    logic [1:0]  c_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REGADDR_W(4), .LOAD_LAT(1), .DRAIN_CYC(3), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_is_load(id_is_load),
        .id_jump(id_jump), .id_halt(id_halt), .mem_req(mem_req), .mem_ready(mem_ready),
        .resume(resume), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush), .pipe_hold(a_pipe_hold),
        .halted(a_halted), .stall_cnt(a_stall_cnt));

    pipe_ctrl_unit #(.REGADDR_W(4), .LOAD_LAT(3), .DRAIN_CYC(3), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_is_load(id_is_load),
        .id_jump(id_jump), .id_halt(id_halt), .mem_req(mem_req), .mem_ready(mem_ready),
        .resume(resume), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .pipe_hold(b_pipe_hold),
        .halted(b_halted), .stall_cnt(b_stall_cnt));

    pipe_ctrl_unit #(.REGADDR_W(4), .LOAD_LAT(1), .DRAIN_CYC(0), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_is_load(id_is_load),
        .id_jump(id_jump), .id_halt(id_halt), .mem_req(mem_req), .mem_ready(mem_ready),
        .resume(resume), .pc_write(c_pc_write), .if_id_write(c_if_id_write),
        .if_id_flush(c_if_id_flush), .id_ex_flush(c_id_ex_flush), .pipe_hold(c_pipe_hold),
        .halted(c_halted), .stall_cnt(c_stall_cnt));

    task automatic idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_is_load = 0; id_jump = 0; id_halt = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; mem_req = 0; mem_ready = 0; resume = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic load(input logic [3:0] rd);
        idle(); id_valid = 1; id_is_load = 1; id_rd = rd;
    endtask

    task automatic use_rs(input logic [3:0] rs);
        idle(); id_valid = 1; id_use_rs = 1; id_rs = rs; id_rd = 4'd9;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cyc();
        checks++; if (a_pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got %b exp 0", a_pc_write); end
        checks++; if ({a_if_id_write, a_if_id_flush, a_id_ex_flush, a_pipe_hold, a_halted} !== 5'b0) begin
            errors++; $display("FAIL rst_outputs got %b exp 00000", {a_if_id_write, a_if_id_flush, a_id_ex_flush, a_pipe_hold, a_halted}); end
        checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", a_stall_cnt); end
        reset = 0;
        @(negedge clk);
        checks++; if ({a_pc_write, a_if_id_write} !== 2'b11) begin errors++; $display("FAIL rst_release_run got %b exp 11", {a_pc_write, a_if_id_write}); end
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        load(4'd3);
        @(negedge clk);
        checks++; if (a_pc_write !== 1'b1) begin errors++; $display("FAIL lu1_load_cycle pc_write got %b exp 1", a_pc_write); end
        cyc();
        use_rs(4'd3);
        @(negedge clk);
        checks++; if ({a_pc_write, a_id_ex_flush} !== 2'b01) begin errors++; $display("FAIL lu1_stall got pc_write/flush %b exp 01", {a_pc_write, a_id_ex_flush}); end
        cyc();
        @(negedge clk);
        checks++; if ({a_pc_write, a_id_ex_flush} !== 2'b10) begin errors++; $display("FAIL lu1_release got pc_write/flush %b exp 10", {a_pc_write, a_id_ex_flush}); end
        checks++; if (a_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu1_stall_cnt got %0d exp 1", a_stall_cnt); end
    endtask

    task automatic test_load_use_lat3();
        logic [3:0] exp_pc;
        do_reset();
        load(4'd5);
        cyc();
        use_rs(4'd5);
        exp_pc = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (b_pc_write !== exp_pc[i]) begin errors++; $display("FAIL lu3_cycle%0d pc_write got %b exp %b", i, b_pc_write, exp_pc[i]); end
            cyc();
        end
        checks++; if (b_stall_cnt !== 16'd3) begin errors++; $display("FAIL lu3_stall_cnt got %0d exp 3", b_stall_cnt); end
        load(4'd0);
        cyc();
        use_rs(4'd0);
        @(negedge clk);
        checks++; if (b_pc_write !== 1'b1) begin errors++; $display("FAIL lu3_r0 pc_write got %b exp 1", b_pc_write); end
        cyc();
        load(4'd7);
        cyc();
        idle(); id_valid = 1; id_rs = 4'd7; id_use_rs = 0; id_rt = 4'd2; id_use_rt = 1;
        @(negedge clk);
        checks++; if (b_pc_write !== 1'b1) begin errors++; $display("FAIL lu3_unused_rs pc_write got %b exp 1", b_pc_write); end
        cyc();
        idle(); id_valid = 1; id_rt = 4'd7; id_use_rt = 1;
        @(negedge clk);
        checks++; if ({b_pc_write, b_id_ex_flush} !== 2'b01) begin errors++; $display("FAIL lu3_rt_match got %b exp 01", {b_pc_write, b_id_ex_flush}); end
    endtask

    task automatic test_mem_hold();
        do_reset();
        load(4'd4);
        cyc();
        use_rs(4'd4);
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({a_pipe_hold, a_pc_write, a_if_id_write, a_id_ex_flush, a_if_id_flush} !== 5'b10000) begin
                errors++; $display("FAIL hold_cycle%0d got %b exp 10000", i, {a_pipe_hold, a_pc_write, a_if_id_write, a_id_ex_flush, a_if_id_flush}); end
            cyc();
        end
        mem_ready = 1;
        @(negedge clk);
        checks++; if ({a_pipe_hold, a_pc_write, a_id_ex_flush} !== 3'b001) begin
            errors++; $display("FAIL hold_sb_frozen got %b exp 001", {a_pipe_hold, a_pc_write, a_id_ex_flush}); end
        cyc();
        mem_req = 0; mem_ready = 0;
        @(negedge clk);
        checks++; if (a_pc_write !== 1'b1) begin errors++; $display("FAIL hold_after pc_write got %b exp 1", a_pc_write); end
        checks++; if (a_stall_cnt !== 16'd5) begin errors++; $display("FAIL hold_stall_cnt got %0d exp 5", a_stall_cnt); end
        checks++; if (c_stall_cnt !== 2'd3) begin errors++; $display("FAIL hold_cnt_saturate got %0d exp 3", c_stall_cnt); end
    endtask

    task automatic test_jump();
        do_reset();
        idle(); id_valid = 1; id_jump = 1; id_rs = 4'd2; id_use_rs = 1;
        @(negedge clk);
        checks++; if ({a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush} !== 4'b1110) begin
            errors++; $display("FAIL jump got %b exp 1110", {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush}); end
        cyc();
        load(4'd6);
        cyc();
        idle(); id_valid = 1; id_jump = 1; id_rs = 4'd6; id_use_rs = 1;
        @(negedge clk);
        checks++; if ({a_pc_write, a_if_id_flush, a_id_ex_flush} !== 3'b001) begin
            errors++; $display("FAIL jr_stall got %b exp 001", {a_pc_write, a_if_id_flush, a_id_ex_flush}); end
        cyc();
        @(negedge clk);
        checks++; if ({a_pc_write, a_if_id_flush, a_id_ex_flush} !== 3'b110) begin
            errors++; $display("FAIL jr_flush got %b exp 110", {a_pc_write, a_if_id_flush, a_id_ex_flush}); end
    endtask

    task automatic test_halt();
        do_reset();
        idle(); id_valid = 1; id_halt = 1;
        @(negedge clk);
        checks++; if ({a_pc_write, a_if_id_write, a_id_ex_flush, a_if_id_flush, a_halted} !== 5'b00110) begin
            errors++; $display("FAIL halt_id got %b exp 00110", {a_pc_write, a_if_id_write, a_id_ex_flush, a_if_id_flush, a_halted}); end
        cyc();
        idle();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (a_halted !== (c == 4)) begin errors++; $display("FAIL halt_drain%0d halted got %b exp %b", c, a_halted, (c == 4)); end
            checks++; if (a_pc_write !== 1'b0) begin errors++; $display("FAIL halt_drain%0d pc_write got %b exp 0", c, a_pc_write); end
            if (c == 1) begin
                checks++; if (c_halted !== 1'b1) begin errors++; $display("FAIL halt_nodrain halted got %b exp 1", c_halted); end
            end
            cyc();
        end
        resume = 1;
        @(negedge clk);
        checks++; if (a_halted !== 1'b1) begin errors++; $display("FAIL resume_cycle halted got %b exp 1", a_halted); end
        cyc();
        resume = 0;
        @(negedge clk);
        checks++; if ({a_halted, a_pc_write, c_halted} !== 3'b010) begin
            errors++; $display("FAIL resume_run got %b exp 010", {a_halted, a_pc_write, c_halted}); end
        // HALT again, with a two-cycle memory hold inside the drain
        do_reset();
        idle(); id_valid = 1; id_halt = 1;
        cyc();
        idle();
        for (int c = 1; c <= 6; c++) begin
            mem_req = (c == 2 || c == 3); mem_ready = 0;
            @(negedge clk);
            checks++; if (a_halted !== (c == 6)) begin errors++; $display("FAIL halt_hold%0d halted got %b exp %b", c, a_halted, (c == 6)); end
            cyc();
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        idle(); id_valid = 1; id_halt = 1;
        cyc();
        idle();
        @(negedge clk);
        checks++; if (a_id_ex_flush !== 1'b1) begin errors++; $display("FAIL mid_drain flush got %b exp 1", a_id_ex_flush); end
        reset = 1;
        #1;
        checks++; if ({a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_pipe_hold, a_halted} !== 6'b0) begin
            errors++; $display("FAIL reset_in_drain got %b exp 000000", {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_pipe_hold, a_halted}); end
        checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_in_drain stall_cnt got %0d exp 0", a_stall_cnt); end
        cyc();
        reset = 0;
        @(negedge clk);
        checks++; if ({a_pc_write, a_halted, a_id_ex_flush} !== 3'b100) begin
            errors++; $display("FAIL after_reset_run got %b exp 100", {a_pc_write, a_halted, a_id_ex_flush}); end
        cyc();
        load(4'd3);
        cyc();
        use_rs(4'd3);
        mem_req = 1; mem_ready = 0;
        @(negedge clk);
        checks++; if (a_pipe_hold !== 1'b1) begin errors++; $display("FAIL mid_hold pipe_hold got %b exp 1", a_pipe_hold); end
        reset = 1;
        #1;
        checks++; if (a_pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_in_hold pipe_hold got %b exp 0", a_pipe_hold); end
        cyc();
        reset = 0;
        mem_req = 0;
        @(negedge clk);
        checks++; if ({a_pc_write, a_id_ex_flush} !== 2'b10) begin
            errors++; $display("FAIL reset_clears_sb got %b exp 10", {a_pc_write, a_id_ex_flush}); end
    endtask

    initial begin
        test_reset();
        test_load_use_lat1();
        test_load_use_lat3();
        test_mem_hold();
        test_jump();
        test_halt();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
